// File: rtl/cache_mem_pkg.sv
// Shared types and constants for the cache/RAM load-store controller.
`timescale 1ns/1ps
package cache_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    CHECK,
    MEM_RD,
    MEM_CAP,
    FILL,
    WR_THRU,
    RESP
  } state_t;

  // Cycles from the accepting edge to the edge where resp_valid is first seen high
  localparam int LAT_HIT  = 3;
  localparam int LAT_MISS = 6;
  localparam int LAT_WR   = 2;

endpackage

// File: rtl/cache_mem_ctrl_sat_counter.sv
// Saturating up-counter with enable; sticks at all-ones, cleared by async reset.
`timescale 1ns/1ps
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_mem_ctrl.sv
// Sequences CPU loads (cache lookup, RAM fill on miss) and write-through stores.
`timescale 1ns/1ps
module cache_mem_ctrl
  import cache_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 28,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic [ADDR_WIDTH-1:0] c_addr,
  output logic                  c_rd,
  input  logic                  c_hit,
  input  logic [DATA_WIDTH-1:0] c_rdata,
  output logic                  c_we,
  output logic [DATA_WIDTH-1:0] c_wdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt
);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [ADDR_WIDTH-1:0] r_c_addr;
  logic                  r_c_rd;
  logic                  r_c_we;
  logic [DATA_WIDTH-1:0] r_c_wdata;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_cs;
  logic                  r_mem_we;
  logic                  r_mem_oe;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  w_hit_en;
  logic                  w_miss_en;

  // Each output register is loaded on the edge that enters the state it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_rdata      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_c_addr     <= '0;
      r_c_rd       <= 1'b0;
      r_c_we       <= 1'b0;
      r_c_wdata    <= '0;
      r_mem_addr   <= '0;
      r_mem_cs     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_oe     <= 1'b1;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr      <= req_addr;
            r_req_ready <= 1'b0;
            r_c_addr    <= req_addr;
            if (req_we) begin
              r_state     <= WR_THRU;
              r_mem_cs    <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_oe    <= 1'b0;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= req_wdata;
              r_c_we      <= 1'b1;
              r_c_wdata   <= req_wdata;
            end else begin
              r_state <= LOOKUP;
              r_c_rd  <= 1'b1;
            end
          end
        end
        LOOKUP: begin
          r_c_rd  <= 1'b0;
          r_state <= CHECK;
        end
        CHECK: begin
          if (c_hit) begin
            r_rdata      <= c_rdata;
            r_resp_rdata <= c_rdata;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_mem_cs   <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_oe   <= 1'b1;
            r_mem_addr <= r_addr;
            r_state    <= MEM_RD;
          end
        end
        MEM_RD: begin
          r_state <= MEM_CAP;
        end
        MEM_CAP: begin
          r_rdata   <= mem_rdata;
          r_mem_cs  <= 1'b0;
          r_c_we    <= 1'b1;
          r_c_addr  <= r_addr;
          r_c_wdata <= mem_rdata;
          r_state   <= FILL;
        end
        FILL: begin
          r_c_we       <= 1'b0;
          r_resp_rdata <= r_rdata;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        WR_THRU: begin
          r_mem_cs     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_oe     <= 1'b1;
          r_c_we       <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: begin
          r_resp_valid <= 1'b0;
          r_req_ready  <= 1'b1;
          r_state      <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Counter enables are decoded from the current state so the count lands with the CHECK edge
  assign w_hit_en  = (r_state == CHECK) &&  c_hit;
  assign w_miss_en = (r_state == CHECK) && !c_hit;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_hit_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_hit_en),
    .o_cnt   (hit_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_miss_cnt (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (w_miss_en),
    .o_cnt   (miss_cnt)
  );

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign c_addr     = r_c_addr;
  assign c_rd       = r_c_rd;
  assign c_we       = r_c_we;
  assign c_wdata    = r_c_wdata;
  assign mem_addr   = r_mem_addr;
  assign mem_cs     = r_mem_cs;
  assign mem_we     = r_mem_we;
  assign mem_oe     = r_mem_oe;
  assign mem_wdata  = r_mem_wdata;

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Directed bench for cache_mem_ctrl: vector table plus back-to-back, reset and saturation sequences.
`timescale 1ns/1ps
module tb_cache_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_we;
  logic [27:0] req_addr;
  logic [31:0] req_wdata;
  logic        c_hit;
  logic [31:0] c_rdata, mem_rdata;

  logic        req_ready, resp_valid, c_rd, c_we, mem_cs, mem_we, mem_oe;
  logic [31:0] resp_rdata, c_wdata, mem_wdata;
  logic [27:0] c_addr, mem_addr;
  logic [15:0] hit_cnt, miss_cnt;

  logic        s_req_ready, s_resp_valid, s_c_rd, s_c_we, s_mem_cs, s_mem_we, s_mem_oe;
  logic [31:0] s_resp_rdata, s_c_wdata, s_mem_wdata;
  logic [27:0] s_c_addr, s_mem_addr;
  logic [2:0]  s_hit_cnt, s_miss_cnt;

  int checks = 0;
  int errors = 0;
  int exp_hit, exp_miss, s_exp_hit, s_exp_miss;

  always #5 clk = ~clk;

  cache_mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .c_addr(c_addr), .c_rd(c_rd), .c_hit(c_hit), .c_rdata(c_rdata),
    .c_we(c_we), .c_wdata(c_wdata),
    .mem_addr(mem_addr), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  // Narrow-counter copy fed the same stimulus, so saturation is reachable in a few requests
  cache_mem_ctrl #(.CNT_WIDTH(3)) dut_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(s_resp_valid), .resp_rdata(s_resp_rdata),
    .c_addr(s_c_addr), .c_rd(s_c_rd), .c_hit(c_hit), .c_rdata(c_rdata),
    .c_we(s_c_we), .c_wdata(s_c_wdata),
    .mem_addr(s_mem_addr), .mem_cs(s_mem_cs), .mem_we(s_mem_we), .mem_oe(s_mem_oe),
    .mem_wdata(s_mem_wdata), .mem_rdata(mem_rdata),
    .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
  );

  typedef struct {
    logic        we;
    logic [27:0] addr;
    logic [31:0] wdata;
    logic        hit;
    logic [31:0] crd;
    logic [31:0] mrd;
    int          lat;
    logic [31:0] rdata;
    int          ncs;
    int          nwe;
    logic [31:0] cwd;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic count_model(input vec_t v);
    if (!v.we) begin
      if (v.hit) begin
        exp_hit++;
        if (s_exp_hit != 7) s_exp_hit++;
      end else begin
        exp_miss++;
        if (s_exp_miss != 7) s_exp_miss++;
      end
    end
  endtask

  task automatic do_req(input vec_t v, input string tag);
    int lat = 0, ncs = 0, nwe = 0;
    logic [31:0] cwd_seen = '0;
    bit addr_ok = 1, bus_ok = 1, ready_ok = 1, overlap = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
    c_hit = v.hit; c_rdata = v.crd; mem_rdata = v.mrd;
    chk({tag, " ready_idle"}, req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k > 1) @(negedge clk);
      if (req_ready) ready_ok = 0;
      if (c_rd && c_addr != v.addr) addr_ok = 0;
      if (c_we) begin
        nwe++; cwd_seen = c_wdata;
        if (c_addr != v.addr) addr_ok = 0;
      end
      if (mem_cs) begin
        ncs++;
        if (mem_addr != v.addr) addr_ok = 0;
        if (v.we && !(mem_we && !mem_oe && mem_wdata == v.wdata)) bus_ok = 0;
        if (!v.we && (mem_we || !mem_oe)) bus_ok = 0;
      end else if (!mem_oe || mem_we) bus_ok = 0;
      if (resp_valid) begin
        lat = k;
        if (c_rd || c_we || mem_cs) overlap = 1;
      end
    end
    count_model(v);
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " resp_rdata"}, resp_rdata, v.rdata);
    chk({tag, " hit_cnt"}, hit_cnt, exp_hit);
    chk({tag, " miss_cnt"}, miss_cnt, exp_miss);
    chk({tag, " sat_hit_cnt"}, s_hit_cnt, s_exp_hit);
    chk({tag, " sat_miss_cnt"}, s_miss_cnt, s_exp_miss);
    chk({tag, " mem_cs_cycles"}, ncs, v.ncs);
    chk({tag, " c_we_cycles"}, nwe, v.nwe);
    if (v.nwe > 0) chk({tag, " c_wdata"}, cwd_seen, v.cwd);
    chk({tag, " addr_ok"}, addr_ok, 1);
    chk({tag, " bus_ok"}, bus_ok, 1);
    chk({tag, " ready_low_busy"}, ready_ok, 1);
    chk({tag, " strobe_overlap"}, overlap, 0);
    @(negedge clk);
    chk({tag, " resp_one_cycle"}, resp_valid, 0);
    chk({tag, " ready_back"}, req_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int first_resp, second_resp, nresp, ready_bad;
    logic [31:0] r1, r2;
    vec_t hv;

    //          we    addr          wdata          hit   c_rdata        mem_rdata      lat rdata          ncs nwe c_wdata
    vecs[0] = '{1'b0, 28'h000011E,  32'h0,         1'b0, 32'hDEADBEEF,  32'h78000000,  6, 32'h78000000,  2,  1, 32'h78000000};
    vecs[1] = '{1'b0, 28'h000011E,  32'h0,         1'b1, 32'h78000000,  32'hDEADBEEF,  3, 32'h78000000,  0,  0, 32'h0};
    vecs[2] = '{1'b1, 28'h0000120,  32'h00000005,  1'b0, 32'h0,         32'h0,         2, 32'h78000000,  1,  1, 32'h00000005};
    vecs[3] = '{1'b0, 28'h0000120,  32'h0,         1'b1, 32'h00000005,  32'h12345678,  3, 32'h00000005,  0,  0, 32'h0};
    vecs[4] = '{1'b0, 28'hFFFFFFF,  32'h0,         1'b0, 32'h0,         32'hA5A5A5A5,  6, 32'hA5A5A5A5,  2,  1, 32'hA5A5A5A5};
    vecs[5] = '{1'b1, 28'h0000000,  32'hFFFFFFFF,  1'b0, 32'h0,         32'h0,         2, 32'hA5A5A5A5,  1,  1, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 28'h0000000,  32'h0,         1'b1, 32'hFFFFFFFF,  32'h0,         3, 32'hFFFFFFFF,  0,  0, 32'h0};

    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    c_hit = 1'b0; c_rdata = '0; mem_rdata = '0;
    exp_hit = 0; exp_miss = 0; s_exp_hit = 0; s_exp_miss = 0;
    repeat (3) @(negedge clk);
    chk("reset req_ready", req_ready, 1);
    chk("reset strobes", {resp_valid, c_rd, c_we, mem_cs, mem_we}, 0);
    chk("reset mem_oe", mem_oe, 1);
    chk("reset data", {resp_rdata, c_wdata, mem_wdata}, 0);
    chk("reset addr", {c_addr, mem_addr}, 0);
    chk("reset counters", {hit_cnt, miss_cnt}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) do_req(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: req_valid held through a miss, second request is a hit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000200;
    c_hit = 1'b0; c_rdata = '0; mem_rdata = 32'h11223344;
    first_resp = 0; second_resp = 0; nresp = 0; ready_bad = 0; r1 = '0; r2 = '0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (resp_valid) begin
        nresp++;
        if (first_resp == 0) begin first_resp = k; r1 = resp_rdata; end
        else begin second_resp = k; r2 = resp_rdata; end
      end
      if (req_ready != (k == 7 || k >= 11)) ready_bad++;
      if (k == 6) begin req_addr = 28'h000011E; c_hit = 1'b1; c_rdata = 32'h78000000; end
      if (k == 8) req_valid = 1'b0;
    end
    exp_miss++; exp_hit++;
    if (s_exp_miss != 7) s_exp_miss++;
    if (s_exp_hit != 7) s_exp_hit++;
    chk("b2b first_resp", first_resp, 6);
    chk("b2b second_resp", second_resp, 10);
    chk("b2b resp_count", nresp, 2);
    chk("b2b ready_pattern_bad", ready_bad, 0);
    chk("b2b rdata1", r1, 32'h11223344);
    chk("b2b rdata2", r2, 32'h78000000);
    chk("b2b hit_cnt", hit_cnt, exp_hit);
    chk("b2b miss_cnt", miss_cnt, exp_miss);

    // Reset asserted during MEM_CAP
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 28'h0000300;
    c_hit = 1'b0; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst pre mem_cs", mem_cs, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst mem_cs", mem_cs, 0);
    chk("rst mem_oe", mem_oe, 1);
    chk("rst req_ready", req_ready, 1);
    chk("rst counters", {hit_cnt, miss_cnt}, 0);
    chk("rst sat counters", {s_hit_cnt, s_miss_cnt}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    nresp = 0; ready_bad = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (resp_valid) nresp++;
      if (!req_ready || c_we || mem_cs) ready_bad++;
    end
    chk("rst no_resp", nresp, 0);
    chk("rst stays_idle_bad", ready_bad, 0);
    exp_hit = 0; exp_miss = 0; s_exp_hit = 0; s_exp_miss = 0;

    // Saturation: nine hits, the 3-bit copy must stick at 7
    hv = '{1'b0, 28'h0000040, 32'h0, 1'b1, 32'h0BADCAFE, 32'h0, 3, 32'h0BADCAFE, 0, 0, 32'h0};
    for (int i = 0; i < 9; i++) do_req(hv, $sformatf("sat%0d", i));
    chk("sat final hit_cnt", hit_cnt, 9);
    chk("sat final narrow hit_cnt", s_hit_cnt, 7);
    chk("sat final narrow miss_cnt", s_miss_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_mem_ctrl.md
Name: cache_mem_ctrl

Overview:
- Controller that sequences CPU load/store requests through the cache and main memory.
- Sits between the CPU datapath (MAR/MBR side), the `cache` block and `single_port_sync_ram_large`.
- Loads: read-hit from the cache; on a miss, read from RAM and fill the cache.
- Stores: write-through with write-allocate.
- Replaces the hand-sequenced cache/RAM handshakes currently done in the CPU load/store microsteps.

Parameters:
- ADDR_WIDTH, 28, memory address width.
- DATA_WIDTH, 32, data word width.
- CNT_WIDTH, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present; held by the CPU until accepted.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_WIDTH  request address (MAR).
- req_wdata  in  DATA_WIDTH  store data (MBR).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DATA_WIDTH  load result; valid while resp_valid is high.
- c_addr  out  ADDR_WIDTH  cache address.
- c_rd  out  1  cache lookup strobe.
- c_hit  in  1  cache hit; sampled the cycle after c_rd.
- c_rdata  in  DATA_WIDTH  cache read data; sampled with c_hit.
- c_we  out  1  cache write strobe.
- c_wdata  out  DATA_WIDTH  cache write data.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_cs  out  1  RAM chip select.
- mem_we  out  1  RAM write enable.
- mem_oe  out  1  RAM output enable. 1 = RAM drives the bus; 0 = controller drives the bus.
- mem_wdata  out  DATA_WIDTH  data driven onto the RAM bus when mem_oe=0 (tristate resolved at top level).
- mem_rdata  in  DATA_WIDTH  RAM bus read value.
- hit_cnt  out  CNT_WIDTH  saturating count of load hits.
- miss_cnt  out  CNT_WIDTH  saturating count of load misses.

Behaviour:
- Reset (async, rst_n=0), effective immediately, including mid-operation:
  - FSM goes to IDLE.
  - req_ready=1.
  - resp_valid=0, c_rd=0, c_we=0, mem_cs=0, mem_we=0, mem_oe=1.
  - resp_rdata, c_addr, c_wdata, mem_addr, mem_wdata = 0.
  - hit_cnt=0, miss_cnt=0.
  - Any in-flight request is dropped and produces no response.
- Outputs are registered; no combinational path from any input to any output.
- FSM states and transitions:
  - IDLE: req_ready=1. When req_valid=1, latch addr/we/wdata and drop req_ready. Next: LOOKUP if we=0, WR_THRU if we=1.
  - LOOKUP: c_rd=1, c_addr=addr. Next: CHECK.
  - CHECK: sample c_hit and c_rdata.
    - Hit: rdata <= c_rdata, hit_cnt++. Next: RESP.
    - Miss: miss_cnt++. Next: MEM_RD.
  - MEM_RD: mem_cs=1, mem_oe=1, mem_we=0, mem_addr=addr. Next: MEM_CAP.
  - MEM_CAP: hold the MEM_RD controls; rdata <= mem_rdata at the end of the cycle. Next: FILL.
  - FILL: mem_cs=0; c_we=1, c_addr=addr, c_wdata=rdata. Next: RESP.
  - WR_THRU: mem_cs=1, mem_we=1, mem_oe=0, mem_addr=addr, mem_wdata=wdata; c_we=1, c_addr=addr, c_wdata=wdata. Next: RESP.
  - RESP: resp_valid=1 for exactly one cycle; all strobes low. Next: IDLE.
    - Loads: resp_rdata is updated.
    - Stores: resp_rdata holds its previous value.
- Latency, counted from the accepting clock edge to the edge on which resp_valid is first seen high:
  - Load hit: 3 cycles.
  - Load miss: 6 cycles.
  - Store: 2 cycles.
- Throughput: one request in flight; no pipelining.
  - req_ready=0 in every state except IDLE.
  - A request presented during RESP is accepted on the following IDLE cycle.
  - Back-to-back requests therefore cost at least 1 extra cycle.
- Strobes c_rd, c_we and mem_cs are never high in the same cycle as resp_valid.
- mem_oe returns to 1 in every state except WR_THRU, so the bus is released after the write.
- Counters:
  - Saturate at 2^CNT_WIDTH-1 with no wrap.
  - Stores affect neither counter.
- Address is used unmodified (no alignment check).
- A load following a store to the same address must hit and return the stored data, because of write-allocate.

Decomposition:
- Package cache_mem_pkg:
  - State enum: IDLE, LOOKUP, CHECK, MEM_RD, MEM_CAP, FILL, WR_THRU, RESP.
  - Latency constants: LAT_HIT=3, LAT_MISS=6, LAT_WR=2.
- One natural sub-module: sat_counter (parameterized width, enable, async active-low clear), instantiated twice for hit_cnt and miss_cnt.

Test Plan:
- Load 'h11E, c_hit=0, mem_rdata='h78000000 -> resp_valid 6 cycles after accept; resp_rdata='h78000000; c_we pulse with c_wdata='h78000000; miss_cnt=1.
- Repeat the load of 'h11E with c_hit=1, c_rdata='h78000000 -> resp_valid after 3 cycles; no mem_cs pulse; hit_cnt=1.
- Store addr 'h120, data 'h00000005 -> within 2 cycles, exactly one WR_THRU cycle with mem_cs=1, mem_we=1, mem_oe=0, mem_wdata='h5 and c_we=1, c_wdata='h5; no counter change.
- Hold req_valid high continuously during a miss -> req_ready stays 0 until IDLE; second request accepted exactly one cycle after resp_valid; no request lost or duplicated.
- Assert rst_n=0 while in MEM_CAP -> immediately mem_cs=0, mem_oe=1, req_ready=1, counters 0; no resp_valid pulse after rst_n deasserts.
- Force hit_cnt to 'hFFFF and issue another load hit -> hit_cnt stays 'hFFFF.
